shared_reg_arbiter: RTL

//  Round-robin arbiter sharing one WIDTH-bit register (a bank of D flip-flops)

---
 rtl/shared_reg_arbiter.sv | 75 +++++++
 1 files changed

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin ownership of one shared register with bounded tenure and a release gap
module shared_reg_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic                   clk,
  input  logic                   re,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(HOLD_MAX) + 1;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] pick;
  logic [CW-1:0] cnt;
  logic          found;
  assign busy = state != IDLE;
  // first requester at or after ptr, wrapping around the requester ring
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % N_REQ]) begin
        found = 1'b1;
        pick  = PW'((int'(ptr) + k) % N_REQ);
      end
    end
  end
  // ownership FSM; q_valid pulses only on edges where the owner writes
  always_ff @(posedge clk or negedge re) begin
    if (!re) begin
      state   <= IDLE;
      gnt     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
      owner   <= '0;
    end else begin
      q_valid <= 1'b0;
      case (state)
        IDLE: if (found) begin
          owner <= pick;
          gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
          ptr   <= (pick == PW'(N_REQ - 1)) ? '0 : pick + 1'b1;
          cnt   <= '0;
          state <= GRANT;
        end
        GRANT: if (req[owner]) begin
          q       <= wdata[int'(owner)*WIDTH +: WIDTH];
          q_valid <= 1'b1;
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(HOLD_MAX - 1)) begin
            gnt   <= '0;
            state <= RELEASE;
          end
        end else begin
          gnt   <= '0;
          state <= RELEASE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
